// File: rtl/fifo_packet.sv
// fifo_packet: packet-aware synchronous FIFO; words become readable only when their packet commits.
// Optional FIFO_PACKET_AUTODROP_EN: an overflow mid-packet drops the packet and discards its remaining words.
module fifo_packet #(
  parameter int unsigned WIDTH                = 8,
  parameter int unsigned DEPTH                = 16,
  parameter string       FWFT                 = "TRUE",
  parameter int unsigned PROG_FULL_THRESHOLD  = DEPTH - 2,
  parameter int unsigned PROG_EMPTY_THRESHOLD = 2,
  localparam int unsigned AW                  = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_WrEn,
  input  logic [WIDTH-1:0] i_WrData,
  input  logic             i_WrLast,
  input  logic             i_WrDrop,
  input  logic             i_RdEn,
  output logic [WIDTH-1:0] o_RdData,
  output logic             o_RdLast,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_ProgFull,
  output logic             o_ProgEmpty,
  output logic             o_OverFlow,
  output logic             o_UnderFlow,
  output logic [AW:0]      o_WrCount,
  output logic [AW:0]      o_RdCount,
  output logic [AW:0]      o_PktCount
);

  localparam int unsigned PW = AW + 1;

  logic [WIDTH:0] r_Mem [DEPTH];
  logic [AW:0]    r_WrPtr;
  logic [AW:0]    r_CommitPtr;
  logic [AW:0]    r_RdPtr;
  logic [AW:0]    r_PktCount;
  logic [WIDTH:0] w_RdEntry;
  logic           w_Full;
  logic           w_Empty;
  logic           w_Discarding;
  logic           w_WrAccept;
  logic           w_WrReject;
  logic           w_RdAccept;
  logic           w_Commit;
  logic           w_PktDone;
  logic           w_AutoDrop;

  // Occupancy and flags straight from the registered pointers
  assign o_WrCount   = r_WrPtr - r_RdPtr;
  assign o_RdCount   = r_CommitPtr - r_RdPtr;
  assign o_PktCount  = r_PktCount;
  assign w_Full      = (o_WrCount == PW'(DEPTH));
  assign w_Empty     = (o_RdCount == '0);
  assign o_Full      = w_Full;
  assign o_Empty     = w_Empty;
  assign o_ProgFull  = (o_WrCount >= PW'(PROG_FULL_THRESHOLD));
  assign o_ProgEmpty = (o_RdCount <= PW'(PROG_EMPTY_THRESHOLD));

  assign w_RdEntry  = r_Mem[r_RdPtr[AW-1:0]];
  assign w_WrAccept = i_WrEn && !w_Full && !i_WrDrop && !w_Discarding;
  assign w_WrReject = i_WrEn && w_Full && !i_WrDrop && !w_Discarding;
  assign w_RdAccept = i_RdEn && !w_Empty;
  assign w_Commit   = w_WrAccept && i_WrLast;
  assign w_PktDone  = w_RdAccept && w_RdEntry[WIDTH];

`ifdef FIFO_PACKET_AUTODROP_EN
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0] r_State;
  logic [0:0] w_NextState;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_State <= ST_IDLE;
    else          r_State <= w_NextState;
  end

  // Discard runs until the tail of the dropped packet has gone by
  always_comb begin
    w_NextState = r_State;
    if (i_WrDrop) begin
      w_NextState = ST_IDLE;
    end else if (r_State == ST_DISCARD) begin
      if (i_WrEn && i_WrLast) w_NextState = ST_IDLE;
    end else if (w_WrReject && !i_WrLast && (r_WrPtr != r_CommitPtr)) begin
      w_NextState = ST_DISCARD;
    end
  end

  assign w_Discarding = (r_State == ST_DISCARD);
  assign w_AutoDrop   = w_WrReject && ((r_WrPtr != r_CommitPtr) || i_WrLast);
`else
  assign w_Discarding = 1'b0;
  assign w_AutoDrop   = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (w_WrAccept) r_Mem[r_WrPtr[AW-1:0]] <= {i_WrLast, i_WrData};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_WrPtr     <= '0;
      r_CommitPtr <= '0;
      r_RdPtr     <= '0;
      r_PktCount  <= '0;
      o_OverFlow  <= 1'b0;
      o_UnderFlow <= 1'b0;
    end else begin
      if (i_WrDrop || w_AutoDrop) begin
        r_WrPtr <= r_CommitPtr;
      end else if (w_WrAccept) begin
        r_WrPtr <= r_WrPtr + PW'(1);
        if (i_WrLast) r_CommitPtr <= r_WrPtr + PW'(1);
      end
      if (w_RdAccept) r_RdPtr <= r_RdPtr + PW'(1);
      if (w_Commit && !w_PktDone)      r_PktCount <= r_PktCount + PW'(1);
      else if (!w_Commit && w_PktDone) r_PktCount <= r_PktCount - PW'(1);
      o_OverFlow  <= w_WrReject;
      o_UnderFlow <= i_RdEn && w_Empty;
    end
  end

  // Read port: head entry shown directly, or loaded on each accepted read
  if (FWFT == "TRUE") begin : g_Fwft
    assign o_RdData = w_Empty ? '0 : w_RdEntry[WIDTH-1:0];
    assign o_RdLast = !w_Empty && w_RdEntry[WIDTH];
  end else begin : g_Std
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        o_RdData <= '0;
        o_RdLast <= 1'b0;
      end else if (w_RdAccept) begin
        o_RdData <= w_RdEntry[WIDTH-1:0];
        o_RdLast <= w_RdEntry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_packet.sv
// tb_fifo_packet: drives a FWFT and a registered-read fifo_packet (DEPTH=8) with the same stimulus
// and compares both against a queue-based packet model; honours FIFO_PACKET_AUTODROP_EN.
module tb_fifo_packet;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             i_Clk = 1'b0;
  logic             i_Rst_n = 1'b0;
  logic             i_WrEn = 1'b0;
  logic [WIDTH-1:0] i_WrData = '0;
  logic             i_WrLast = 1'b0;
  logic             i_WrDrop = 1'b0;
  logic             i_RdEn = 1'b0;

  logic [WIDTH-1:0] aRdData, bRdData;
  logic             aRdLast, bRdLast, aFull, bFull, aEmpty, bEmpty;
  logic             aProgFull, bProgFull, aProgEmpty, bProgEmpty;
  logic             aOverFlow, bOverFlow, aUnderFlow, bUnderFlow;
  logic [AW:0]      aWrCount, bWrCount, aRdCount, bRdCount, aPktCount, bPktCount;

  fifo_packet #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT("TRUE")) u_DutFwft (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_WrEn(i_WrEn), .i_WrData(i_WrData),
    .i_WrLast(i_WrLast), .i_WrDrop(i_WrDrop), .i_RdEn(i_RdEn),
    .o_RdData(aRdData), .o_RdLast(aRdLast), .o_Full(aFull), .o_Empty(aEmpty),
    .o_ProgFull(aProgFull), .o_ProgEmpty(aProgEmpty), .o_OverFlow(aOverFlow),
    .o_UnderFlow(aUnderFlow), .o_WrCount(aWrCount), .o_RdCount(aRdCount),
    .o_PktCount(aPktCount)
  );

  fifo_packet #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT("FALSE")) u_DutStd (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_WrEn(i_WrEn), .i_WrData(i_WrData),
    .i_WrLast(i_WrLast), .i_WrDrop(i_WrDrop), .i_RdEn(i_RdEn),
    .o_RdData(bRdData), .o_RdLast(bRdLast), .o_Full(bFull), .o_Empty(bEmpty),
    .o_ProgFull(bProgFull), .o_ProgEmpty(bProgEmpty), .o_OverFlow(bOverFlow),
    .o_UnderFlow(bUnderFlow), .o_WrCount(bWrCount), .o_RdCount(bRdCount),
    .o_PktCount(bPktCount)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  // Model: committed words (readable) and staged words of the open packet, each {last, data}
  logic [WIDTH:0] mCommitted[$];
  logic [WIDTH:0] mStaged[$];
  bit             mDiscard;
  logic [WIDTH:0] mStdOut;
  bit             mOvf;
  bit             mUnf;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelPkts();
    int n = 0;
    foreach (mCommitted[i]) if (mCommitted[i][WIDTH]) n++;
    return n;
  endfunction

  task automatic modelReset();
    mCommitted.delete();
    mStaged.delete();
    mDiscard = 0;
    mStdOut  = '0;
    mOvf     = 0;
    mUnf     = 0;
  endtask

  task automatic checkAll();
    int total = mCommitted.size() + mStaged.size();
    int rdc   = mCommitted.size();
    checkEq("wrcount",    aWrCount,   total);
    checkEq("rdcount",    aRdCount,   rdc);
    checkEq("pktcount",   aPktCount,  modelPkts());
    checkEq("full",       aFull,      total == DEPTH);
    checkEq("empty",      aEmpty,     rdc == 0);
    checkEq("progfull",   aProgFull,  total >= DEPTH - 2);
    checkEq("progempty",  aProgEmpty, rdc <= 2);
    checkEq("overflow",   aOverFlow,  mOvf);
    checkEq("underflow",  aUnderFlow, mUnf);
    checkEq("std_wrcount",  bWrCount,   total);
    checkEq("std_rdcount",  bRdCount,   rdc);
    checkEq("std_pktcount", bPktCount,  modelPkts());
    checkEq("std_flags", {bFull, bEmpty, bProgFull, bProgEmpty, bOverFlow, bUnderFlow},
            {total == DEPTH, rdc == 0, total >= DEPTH - 2, rdc <= 2, mOvf, mUnf});
    if (rdc != 0) begin
      checkEq("fwft_data", aRdData, mCommitted[0][WIDTH-1:0]);
      checkEq("fwft_last", aRdLast, mCommitted[0][WIDTH]);
    end
    checkEq("std_data", bRdData, mStdOut[WIDTH-1:0]);
    checkEq("std_last", bRdLast, mStdOut[WIDTH]);
  endtask

  // One clock: drive inputs, advance the model with pre-edge state, check after the edge
  task automatic step(input bit wrEn, input logic [WIDTH-1:0] data, input bit last,
                      input bit drop, input bit rdEn);
    bit full, empty;
    i_WrEn = wrEn; i_WrData = data; i_WrLast = last; i_WrDrop = drop; i_RdEn = rdEn;
    full  = (mCommitted.size() + mStaged.size()) == DEPTH;
    empty = (mCommitted.size() == 0);
    mOvf = 0;
    mUnf = 0;
    if (rdEn) begin
      if (empty) mUnf = 1;
      else       mStdOut = mCommitted.pop_front();
    end
    if (drop) begin
      mStaged.delete();
      mDiscard = 0;
    end else if (wrEn) begin
      if (mDiscard) begin
        if (last) mDiscard = 0;
      end else if (!full) begin
        mStaged.push_back({last, data});
        if (last) begin
          foreach (mStaged[i]) mCommitted.push_back(mStaged[i]);
          mStaged.delete();
        end
      end else begin
        mOvf = 1;
`ifdef FIFO_PACKET_AUTODROP_EN
        if (!last && mStaged.size() != 0) mDiscard = 1;
        mStaged.delete();
`endif
      end
    end
    @(posedge i_Clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock
  task automatic asyncReset();
    #2;
    i_WrEn = 0; i_WrDrop = 0; i_RdEn = 0; i_WrLast = 0;
    i_Rst_n = 0;
    #1;
    checkEq("arst_wrcount",  aWrCount,  0);
    checkEq("arst_rdcount",  aRdCount,  0);
    checkEq("arst_pktcount", aPktCount, 0);
    checkEq("arst_empty",    aEmpty,    1);
    checkEq("arst_std_data", bRdData,   0);
    modelReset();
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge i_Clk);
    #1;
    checkAll();
    checkEq("rst_fwft_data", aRdData, 0);
    checkEq("rst_fwft_last", aRdLast, 0);
    @(negedge i_Clk);
    i_Rst_n = 1;

    // Three-word packet stays invisible until its last word lands
    step(1, 8'h10, 0, 0, 0); checkEq("p1_empty_a", aEmpty, 1);
    step(1, 8'h11, 0, 0, 0); checkEq("p1_empty_b", aEmpty, 1);
    step(1, 8'h12, 1, 0, 0);
    checkEq("p1_rdcount", aRdCount, 3);
    checkEq("p1_pktcount", aPktCount, 1);
    checkEq("p1_head", aRdData, 8'h10);
    step(0, '0, 0, 0, 1); checkEq("p1_second", aRdData, 8'h11);
    step(0, '0, 0, 0, 1); checkEq("p1_third", {aRdLast, aRdData}, 9'h112);
    step(0, '0, 0, 0, 1); checkEq("p1_drained", aEmpty, 1);

    // Dropped partial packet leaves no trace
    step(1, 8'h20, 0, 0, 0);
    step(1, 8'h21, 0, 0, 0);
    step(1, 8'h22, 0, 1, 0);
    checkEq("p2_wrcount", aWrCount, 0);
    checkEq("p2_empty", aEmpty, 1);
    step(1, 8'h30, 1, 0, 0);
    checkEq("p2_only", {aRdLast, aRdData}, 9'h130);
    checkEq("p2_rdcount", aRdCount, 1);
    step(0, '0, 0, 0, 1);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), i == 7, 0, 0);
    checkEq("p3_full", aFull, 1);
    step(1, 8'h99, 0, 0, 1);
    checkEq("p3_ovf", aOverFlow, 1);
    checkEq("p3_wrcount", aWrCount, 7);
    idle();
    checkEq("p3_ovf_clear", aOverFlow, 0);
    for (int i = 0; i < 7; i++) step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    checkEq("p3_unf", aUnderFlow, 1);
    idle();
    checkEq("p3_unf_clear", aUnderFlow, 0);

    // Oversized packet
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h50 + i), i == 9, 0, 0);
`ifdef FIFO_PACKET_AUTODROP_EN
      if (i == 8) checkEq("p4_autodrop_wrcount", aWrCount, 0);
`else
      if (i == 8) checkEq("p4_wrcount", aWrCount, 8);
`endif
    end
    step(0, '0, 0, 1, 0);
    step(1, 8'h60, 0, 0, 0);
    step(1, 8'h61, 1, 0, 0);
    checkEq("p4_pktcount", aPktCount, 1);
    checkEq("p4_head", aRdData, 8'h60);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);

    // Registered read latency, then async reset mid-packet
    step(1, 8'hA5, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    checkEq("p5_std_data", {bRdLast, bRdData}, 9'h1A5);
    step(1, 8'h01, 1, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    asyncReset();
    idle();

    // Randomized traffic with alternating read pressure to reach full and empty
    for (int c = 0; c < 3000; c++) begin
      int rdPct = ((c / 150) % 2 == 0) ? 15 : 70;
      if (c == 1700) begin
        asyncReset();
      end
      step($urandom_range(0, 99) < 75,
           8'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 99) < rdPct);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
